// File: rtl/map_mem_arbiter_pkg.sv
// Shared types and constants for the maze cell memory arbiter (package map_arb_pkg).
package map_arb_pkg;

    localparam int GRID_DEF     = 19;
    localparam int ADDR_W_DEF   = 9;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VGA  = 2'd1,
        MV   = 2'd2,
        GEN  = 2'd3
    } req_tag_e;

    localparam logic [1:0] ST_SETUP = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic       WALL     = 1'b1;

endpackage

// File: rtl/map_addr_calc.sv
// Combinational (x, y) -> linear cell address with out-of-range detection.
module map_addr_calc
    import map_arb_pkg::*;
#(
    parameter int GRID   = GRID_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [4:0]        x_i,
    input  logic [4:0]        y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              oob_o
);

    always_comb begin
        oob_o = (int'(x_i) >= GRID) || (int'(y_i) >= GRID);
        // In-range cells always fit, since GRID*GRID <= 2^ADDR_W.
        if (oob_o)
            addr_o = '0;
        else
            addr_o = ADDR_W'(y_i) * ADDR_W'(GRID) + ADDR_W'(x_i);
    end

endmodule

// File: rtl/map_mem_arbiter.sv
// Single-port maze memory arbiter for VGA, move and generator requesters.
// Optional starvation guard for move/generator: define MAP_ARB_STARVE_GUARD_EN.
module map_mem_arbiter
    import map_arb_pkg::*;
#(
    parameter int GRID     = GRID_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_sys,
    input  logic [1:0]        state,
    input  logic              vga_req,
    input  logic              mv_req,
    input  logic              gen_req,
    input  logic [4:0]        vga_x,
    input  logic [4:0]        vga_y,
    input  logic [4:0]        mv_x,
    input  logic [4:0]        mv_y,
    input  logic [4:0]        gen_x,
    input  logic [4:0]        gen_y,
    input  logic              gen_wdata,
    output logic              vga_gnt,
    output logic              mv_gnt,
    output logic              gen_gnt,
    output logic              vga_rvalid,
    output logic              mv_rvalid,
    output logic              rdata,
    output logic              oob,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata
);

    req_tag_e          win;
    req_tag_e          tag_q, tag_d;
    logic              rd_oob_q, rd_oob_d;
    logic              last_q, last_d;
    logic              vga_el, mv_el, gen_el;
    logic              mv_starve, gen_starve;
    logic [4:0]        x_sel, y_sel;
    logic [ADDR_W-1:0] addr_c;
    logic              oob_c;

    assign vga_el = vga_req;
    assign mv_el  = mv_req  && (state == ST_PLAY);
    assign gen_el = gen_req && (state == ST_SETUP);

`ifdef MAP_ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] mv_wait_q, mv_wait_d, gen_wait_q, gen_wait_d;

    assign mv_starve  = mv_el  && (mv_wait_q  == WW'(MAX_WAIT));
    assign gen_starve = gen_el && (gen_wait_q == WW'(MAX_WAIT));

    always_comb begin
        mv_wait_d  = mv_wait_q;
        gen_wait_d = gen_wait_q;
        if (win == MV)
            mv_wait_d = '0;
        else if (mv_el && (mv_wait_q != WW'(MAX_WAIT)))
            mv_wait_d = mv_wait_q + 1'b1;
        if (win == GEN)
            gen_wait_d = '0;
        else if (gen_el && (gen_wait_q != WW'(MAX_WAIT)))
            gen_wait_d = gen_wait_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            mv_wait_q  <= '0;
            gen_wait_q <= '0;
        end else begin
            mv_wait_q  <= mv_wait_d;
            gen_wait_q <= gen_wait_d;
        end
    end
`else
    assign mv_starve  = 1'b0;
    assign gen_starve = 1'b0;
`endif

    // Grants are held off while reset is asserted so the port is quiet.
    always_comb begin
        win = NONE;
        if (rst_sys)
            win = NONE;
        else if (mv_starve && (!gen_starve || !last_q))
            win = MV;
        else if (gen_starve)
            win = GEN;
        else if (vga_el)
            win = VGA;
        else if (mv_el && (!gen_el || !last_q))
            win = MV;
        else if (gen_el)
            win = GEN;
    end

    assign vga_gnt = (win == VGA);
    assign mv_gnt  = (win == MV);
    assign gen_gnt = (win == GEN);

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        case (win)
            VGA:     begin x_sel = vga_x; y_sel = vga_y; end
            MV:      begin x_sel = mv_x;  y_sel = mv_y;  end
            GEN:     begin x_sel = gen_x; y_sel = gen_y; end
            default: begin x_sel = '0;    y_sel = '0;    end
        endcase
    end

    map_addr_calc #(
        .GRID   (GRID),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .x_i    (x_sel),
        .y_i    (y_sel),
        .addr_o (addr_c),
        .oob_o  (oob_c)
    );

    always_comb begin
        oob       = (win != NONE) && oob_c;
        mem_en    = (win != NONE) && !oob_c;
        mem_we    = (win == GEN)  && !oob_c;
        mem_addr  = (win != NONE) ? addr_c : '0;
        mem_wdata = (win == GEN)  ? gen_wdata : 1'b0;
    end

    always_comb begin
        tag_d    = NONE;
        rd_oob_d = 1'b0;
        last_d   = last_q;
        if (win == VGA || win == MV) begin
            tag_d    = win;
            rd_oob_d = oob_c;
        end
        if (win == MV)
            last_d = 1'b1;
        else if (win == GEN)
            last_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            tag_q    <= NONE;
            rd_oob_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            rd_oob_q <= rd_oob_d;
            last_q   <= last_d;
        end
    end

    // Out-of-range reads return a wall without touching the memory.
    assign vga_rvalid = (tag_q == VGA);
    assign mv_rvalid  = (tag_q == MV);
    assign rdata      = (tag_q == NONE) ? 1'b0 : (rd_oob_q ? WALL : mem_rdata);

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Directed self-checking bench for map_mem_arbiter.
module tb_map_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_sys;
    logic [1:0] state;
    logic       vga_req, mv_req, gen_req;
    logic [4:0] vga_x, vga_y, mv_x, mv_y, gen_x, gen_y;
    logic       gen_wdata;
    logic       vga_gnt, mv_gnt, gen_gnt;
    logic       vga_rvalid, mv_rvalid, rdata, oob;
    logic       mem_en, mem_we, mem_wdata, mem_rdata;
    logic [8:0] mem_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    map_mem_arbiter dut (
        .clk        (clk),
        .rst_sys    (rst_sys),
        .state      (state),
        .vga_req    (vga_req),
        .mv_req     (mv_req),
        .gen_req    (gen_req),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .mv_x       (mv_x),
        .mv_y       (mv_y),
        .gen_x      (gen_x),
        .gen_y      (gen_y),
        .gen_wdata  (gen_wdata),
        .vga_gnt    (vga_gnt),
        .mv_gnt     (mv_gnt),
        .gen_gnt    (gen_gnt),
        .vga_rvalid (vga_rvalid),
        .mv_rvalid  (mv_rvalid),
        .rdata      (rdata),
        .oob        (oob),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        state = 2'b00; vga_req = 0; mv_req = 0; gen_req = 0;
        vga_x = 0; vga_y = 0; mv_x = 0; mv_y = 0; gen_x = 0; gen_y = 0;
        gen_wdata = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_sys = 1;
        tick();
        rst_sys = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_sys = 1;
        vga_req = 1;
        #2;
        checks++; if ({vga_gnt, mv_gnt, gen_gnt} !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b want=000", {vga_gnt, mv_gnt, gen_gnt}); end
        checks++; if ({vga_rvalid, mv_rvalid, rdata, oob} !== 4'b0000) begin errors++; $display("FAIL reset_resp got=%b want=0000", {vga_rvalid, mv_rvalid, rdata, oob}); end
        checks++; if ({mem_en, mem_we, mem_wdata} !== 3'b000) begin errors++; $display("FAIL reset_mem got=%b want=000", {mem_en, mem_we, mem_wdata}); end
        checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
        tick();
        rst_sys = 0;
        vga_req = 0;
    endtask

    task automatic test_mv_read();
        do_reset();
        state = 2'b01; mv_req = 1; mv_x = 3; mv_y = 2;
        #1;
        checks++; if (mv_gnt !== 1'b1) begin errors++; $display("FAIL mv_gnt got=%b want=1", mv_gnt); end
        checks++; if (mem_addr !== 9'd41) begin errors++; $display("FAIL mv_addr got=%0d want=41", mem_addr); end
        checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL mv_strobes got=%b want=10", {mem_en, mem_we}); end
        tick();
        mv_req = 0; mem_rdata = 1;
        #1;
        checks++; if ({mv_rvalid, vga_rvalid, rdata} !== 3'b101) begin errors++; $display("FAIL mv_rvalid_1 got=%b want=101", {mv_rvalid, vga_rvalid, rdata}); end
        mem_rdata = 0;
        #1;
        checks++; if (rdata !== 1'b0) begin errors++; $display("FAIL mv_rdata_0 got=%b want=0", rdata); end
        tick();
        checks++; if (mv_rvalid !== 1'b0) begin errors++; $display("FAIL mv_rvalid_drop got=%b want=0", mv_rvalid); end
    endtask

    task automatic test_gen_write();
        do_reset();
        state = 2'b00; gen_req = 1; gen_x = 18; gen_y = 18; gen_wdata = 1;
        #1;
        checks++; if (gen_gnt !== 1'b1) begin errors++; $display("FAIL gen_gnt got=%b want=1", gen_gnt); end
        checks++; if (mem_addr !== 9'd360) begin errors++; $display("FAIL gen_addr got=%0d want=360", mem_addr); end
        checks++; if ({mem_en, mem_we, mem_wdata} !== 3'b111) begin errors++; $display("FAIL gen_strobes got=%b want=111", {mem_en, mem_we, mem_wdata}); end
        tick();
        gen_req = 0;
        #1;
        checks++; if ({vga_rvalid, mv_rvalid} !== 2'b00) begin errors++; $display("FAIL gen_no_rvalid got=%b want=00", {vga_rvalid, mv_rvalid}); end
    endtask

    task automatic test_vga_priority();
        int first;
        first = 0;
        do_reset();
        state = 2'b01; vga_req = 1; vga_x = 1; vga_y = 1; mv_req = 1; mv_x = 3; mv_y = 2;
        #1;
        checks++; if ({vga_gnt, mv_gnt} !== 2'b10) begin errors++; $display("FAIL prio_gnt got=%b want=10", {vga_gnt, mv_gnt}); end
        checks++; if (mem_addr !== 9'd20) begin errors++; $display("FAIL prio_addr got=%0d want=20", mem_addr); end
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) tick();
            #1;
            if (mv_gnt === 1'b1 && first == 0) begin
                first = c;
                checks++; if ({vga_gnt, mem_addr} !== {1'b0, 9'd41}) begin errors++; $display("FAIL starve_gnt_addr got=%b/%0d want=0/41", vga_gnt, mem_addr); end
                tick();
                mv_req = 0;
                #1;
            end
        end
`ifdef MAP_ARB_STARVE_GUARD_EN
        checks++; if (first !== 9) begin errors++; $display("FAIL starve_cycle got=%0d want=9", first); end
`else
        checks++; if (first !== 0) begin errors++; $display("FAIL starve_cycle got=%0d want=0", first); end
`endif
        vga_req = 0; mv_req = 0;
        tick();
    endtask

    task automatic test_oob();
        do_reset();
        state = 2'b01; mv_req = 1; mv_x = 19; mv_y = 0;
        #1;
        checks++; if ({mv_gnt, oob, mem_en} !== 3'b110) begin errors++; $display("FAIL oob_grant got=%b want=110", {mv_gnt, oob, mem_en}); end
        tick();
        mv_req = 0; mem_rdata = 0;
        #1;
        checks++; if ({mv_rvalid, rdata} !== 2'b11) begin errors++; $display("FAIL oob_read got=%b want=11", {mv_rvalid, rdata}); end
    endtask

    task automatic test_eligibility();
        int cnt;
        cnt = 0;
        do_reset();
        state = 2'b01; gen_req = 1; gen_x = 2; gen_y = 0; gen_wdata = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (gen_gnt === 1'b1) cnt++;
            tick();
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL gen_inelig got=%0d want=0", cnt); end
        state = 2'b00;
        #1;
        checks++; if ({gen_gnt, mem_addr} !== {1'b1, 9'd2}) begin errors++; $display("FAIL gen_switch got=%b/%0d want=1/2", gen_gnt, mem_addr); end
        tick();
        gen_req = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        state = 2'b01; vga_req = 1; vga_x = 0; vga_y = 1; mv_req = 1; mv_x = 5; mv_y = 0;
        mem_rdata = 1;
        #1;
        checks++; if ({vga_gnt, mv_gnt, mem_addr} !== {2'b10, 9'd19}) begin errors++; $display("FAIL b2b_c1 got=%b/%0d want=10/19", {vga_gnt, mv_gnt}, mem_addr); end
        tick();
        vga_req = 0;
        #1;
        checks++; if ({mv_gnt, vga_rvalid, mv_rvalid, rdata, mem_addr} !== {4'b1101, 9'd5}) begin errors++; $display("FAIL b2b_c2 got=%b/%0d want=1101/5", {mv_gnt, vga_rvalid, mv_rvalid, rdata}, mem_addr); end
        tick();
        mv_req = 0; mem_rdata = 0;
        #1;
        checks++; if ({vga_rvalid, mv_rvalid, rdata} !== 3'b010) begin errors++; $display("FAIL b2b_c3 got=%b want=010", {vga_rvalid, mv_rvalid, rdata}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        state = 2'b01; vga_req = 1; vga_x = 4; vga_y = 4; mem_rdata = 1;
        #1;
        checks++; if (vga_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got=%b want=1", vga_gnt); end
        tick();
        vga_req = 0;
        rst_sys = 1;
        #1;
        checks++; if ({vga_rvalid, mv_rvalid, rdata, oob, mem_en, mem_we, vga_gnt} !== 7'b0) begin errors++; $display("FAIL mid_reset got=%b want=0000000", {vga_rvalid, mv_rvalid, rdata, oob, mem_en, mem_we, vga_gnt}); end
        checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL mid_addr got=%0d want=0", mem_addr); end
        tick();
        rst_sys = 0;
        tick();
        checks++; if (vga_rvalid !== 1'b0) begin errors++; $display("FAIL mid_after got=%b want=0", vga_rvalid); end
    endtask

    initial begin
        clear_inputs();
        rst_sys = 1;
        test_reset();
        test_mv_read();
        test_gen_write();
        test_vga_priority();
        test_oob();
        test_eligibility();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
